usr_deser: RTL and testbench

USR_DESER -- requirements
Module: usr_deser

---
 rtl/usr_deser.sv | 142 ++++++++++++++
 tb/tb_usr_deser.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/usr_deser.sv
// ---------------------------------------------------------------------------
// usr_deser -- serial-to-parallel deserializer with a one-word holding register
//
// Bits arrive one per clk edge while sin_valid is high. A bit with sin_first
// set starts a new word. Once WIDTH bits have been gathered, the word is handed
// to a holding register (dout/dout_valid) that works as a valid/ready output.
// The holding register is separate from the receive FSM, so the next word can
// be received while the previous one waits for the consumer.
//
// Parameters
//   WIDTH      word width in bits (2..16)
//   MSB_FIRST  0: first received bit goes to dout[0]; 1: to dout[WIDTH-1]
//
// Ports
//   clk         rising-edge clock
//   clr_n       asynchronous active-low reset
//   sin         serial data bit
//   sin_valid   qualifies sin; one bit is accepted per edge
//   sin_first   marks the accepted bit as bit 0 of a new word
//   dout        assembled word (holding register)
//   dout_valid  dout holds an unconsumed word
//   dout_ready  consumer takes dout when dout_valid is high on the same edge
//   busy        a word is partially received
//   bit_cnt     bits of the current word accepted so far
//   overrun     sticky: a completed word was dropped, holding register full
//   frame_err   sticky: sin_first arrived in the middle of a word
//   err_clr     synchronous clear of overrun and frame_err
// ---------------------------------------------------------------------------
module usr_deser #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sin_first,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic [4:0]       bit_cnt,
  output logic             overrun,
  output logic             frame_err,
  input  logic             err_clr
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] shreg, shreg_next;
  logic [4:0]       cnt_next;
  logic [4:0]       pos;
  logic [4:0]       first_pos;
  logic             word_done;
  logic             frame_hit;
  logic             load;
  logic             drop;

  // Bit positions in the shift register; with MSB_FIRST the order is mirrored.
  assign first_pos = MSB_FIRST ? 5'(WIDTH - 1) : 5'd0;
  assign pos       = MSB_FIRST ? (5'(WIDTH - 1) - bit_cnt) : bit_cnt;

  // Receive FSM: next state, next bit count and next shift register contents.
  // A flagged bit always restarts the word; clearing the register first keeps
  // stale bits of an abandoned word from leaking into the new one.
  always_comb begin
    state_next = state;
    cnt_next   = bit_cnt;
    shreg_next = shreg;
    word_done  = 1'b0;
    frame_hit  = 1'b0;
    if (sin_valid) begin
      if (sin_first) begin
        frame_hit  = (state == SHIFT);
        shreg_next = '0;
        for (int i = 0; i < WIDTH; i++) begin
          if (5'(i) == first_pos) shreg_next[i] = sin;
        end
        cnt_next   = 5'd1;
        state_next = SHIFT;
      end else if (state == SHIFT) begin
        for (int i = 0; i < WIDTH; i++) begin
          if (5'(i) == pos) shreg_next[i] = sin;
        end
        if (bit_cnt == 5'(WIDTH - 1)) begin
          word_done  = 1'b1;
          cnt_next   = 5'd0;
          state_next = IDLE;
        end else begin
          cnt_next = bit_cnt + 5'd1;
        end
      end
    end
  end

  // A completed word loads when the holding register is empty or is being
  // emptied on this very edge; otherwise it is lost.
  assign load = word_done && (!dout_valid || dout_ready);
  assign drop = word_done && dout_valid && !dout_ready;

  assign busy = (state == SHIFT);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state   <= IDLE;
      bit_cnt <= 5'd0;
      shreg   <= '0;
    end else begin
      state   <= state_next;
      bit_cnt <= cnt_next;
      shreg   <= shreg_next;
    end
  end

  // Holding register: dout only changes while it is being (re)loaded.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (load) begin
      dout       <= shreg_next;
      dout_valid <= 1'b1;
    end else if (dout_valid && dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

  // Sticky error flags; a new error on the same edge beats err_clr.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (drop) overrun <= 1'b1;
      else if (err_clr) overrun <= 1'b0;
      if (frame_hit) frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_usr_deser.sv
// Testbench for usr_deser: an LSB-first and an MSB-first instance share all
// inputs. Expected words are queued when sent and compared when consumed.
module tb_usr_deser;

  logic       clk = 1'b0;
  logic       clr_n, sin, sin_valid, sin_first, dout_ready, err_clr;
  logic [3:0] dout0, dout1;
  logic       dv0, dv1, busy0, busy1, ov0, ov1, fe0, fe1;
  logic [4:0] cnt0, cnt1;

  int checks = 0;
  int errors = 0;

  logic [3:0] q0[$];
  logic [3:0] q1[$];

  always #5 clk = ~clk;

  usr_deser #(.WIDTH(4), .MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .clr_n(clr_n), .sin(sin), .sin_valid(sin_valid),
    .sin_first(sin_first), .dout(dout0), .dout_valid(dv0),
    .dout_ready(dout_ready), .busy(busy0), .bit_cnt(cnt0),
    .overrun(ov0), .frame_err(fe0), .err_clr(err_clr)
  );

  usr_deser #(.WIDTH(4), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .clr_n(clr_n), .sin(sin), .sin_valid(sin_valid),
    .sin_first(sin_first), .dout(dout1), .dout_valid(dv1),
    .dout_ready(dout_ready), .busy(busy1), .bit_cnt(cnt1),
    .overrun(ov1), .frame_err(fe1), .err_clr(err_clr)
  );

  // Counts one comparison and reports it when observed and expected differ.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] rev4(input logic [3:0] w);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = w[3-i];
    return r;
  endfunction

  // Presents one serial bit for exactly one rising edge.
  task automatic applyStimulus(input logic b, input logic first);
    @(negedge clk);
    sin       = b;
    sin_valid = 1'b1;
    sin_first = first;
    @(posedge clk);
    #1;
    sin_valid = 1'b0;
    sin_first = 1'b0;
    sin       = 1'b0;
  endtask

  // Sends a word LSB first (bit 0 flagged); optionally queues it as deliverable.
  task automatic sendWord(input logic [3:0] w, input bit push);
    logic [3:0] t;
    t = w;
    if (push) begin
      q0.push_back(w);
      q1.push_back(rev4(w));
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(t[0], i == 0);
      t = t >> 1;
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_dout0"}, 32'(dout0), 32'h0);
    checkOutput({tag, "_dout1"}, 32'(dout1), 32'h0);
    checkOutput({tag, "_dv"},    32'({dv0, dv1}), 32'h0);
    checkOutput({tag, "_busy"},  32'({busy0, busy1}), 32'h0);
    checkOutput({tag, "_cnt0"},  32'(cnt0), 32'h0);
    checkOutput({tag, "_cnt1"},  32'(cnt1), 32'h0);
    checkOutput({tag, "_ov"},    32'({ov0, ov1}), 32'h0);
    checkOutput({tag, "_fe"},    32'({fe0, fe1}), 32'h0);
  endtask

  // Scoreboard: a word is consumed on the edge after a cycle with valid and ready.
  always @(negedge clk) begin
    if (clr_n && dv0 && dout_ready) begin
      if (q0.size() > 0) checkOutput("sb0", 32'(dout0), 32'(q0.pop_front()));
      else checkOutput("sb0_extra", 32'(dv0), 32'h0);
    end
    if (clr_n && dv1 && dout_ready) begin
      if (q1.size() > 0) checkOutput("sb1", 32'(dout1), 32'(q1.pop_front()));
      else checkOutput("sb1_extra", 32'(dv1), 32'h0);
    end
  end

  initial begin
    clr_n      = 1'b0;
    sin        = 1'b0;
    sin_valid  = 1'b0;
    sin_first  = 1'b0;
    dout_ready = 1'b1;
    err_clr    = 1'b0;
    #12;
    checkReset("reset");
    @(negedge clk);
    clr_n = 1'b1;

    // Bits 1,0,1,1 with the consumer ready.
    $display("[TB] basic word");
    q0.push_back(4'b1101);
    q1.push_back(4'b1011);
    applyStimulus(1'b1, 1'b1);
    checkOutput("basic_busy", 32'(busy0), 32'h1);
    checkOutput("basic_cnt1", 32'(cnt0), 32'h1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("basic_cnt2", 32'(cnt0), 32'h2);
    applyStimulus(1'b1, 1'b0);
    checkOutput("basic_cnt3", 32'(cnt1), 32'h3);
    applyStimulus(1'b1, 1'b0);
    checkOutput("basic_dv", 32'({dv0, dv1}), 32'h3);
    checkOutput("basic_dout0", 32'(dout0), 32'hD);
    checkOutput("basic_dout1", 32'(dout1), 32'hB);
    checkOutput("basic_idle", 32'({busy0, busy1}), 32'h0);
    checkOutput("basic_cnt0", 32'(cnt0), 32'h0);
    @(posedge clk); #1;
    checkOutput("basic_dv_1cyc", 32'({dv0, dv1}), 32'h0);
    checkOutput("basic_dout_hold", 32'(dout0), 32'hD);

    // Overrun: consumer stalled, second word is dropped.
    $display("[TB] overrun");
    dout_ready = 1'b0;
    sendWord(4'hA, 1'b1);
    sendWord(4'h5, 1'b0);
    checkOutput("ovr_dout0", 32'(dout0), 32'hA);
    checkOutput("ovr_dout1", 32'(dout1), 32'(rev4(4'hA)));
    checkOutput("ovr_flag", 32'({ov0, ov1}), 32'h3);
    checkOutput("ovr_no_fe", 32'(fe0), 32'h0);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    checkOutput("ovr_clr", 32'({ov0, ov1}), 32'h0);
    checkOutput("ovr_dv_held", 32'(dv0), 32'h1);
    dout_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("ovr_drained", 32'(dv0), 32'h0);

    // Framing error: restart after two bits with 0,0,1,1.
    $display("[TB] framing error");
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0);
    q0.push_back(4'hC);
    q1.push_back(rev4(4'hC));
    applyStimulus(1'b0, 1'b1);
    checkOutput("fe_flag", 32'({fe0, fe1}), 32'h3);
    checkOutput("fe_cnt", 32'(cnt0), 32'h1);
    checkOutput("fe_busy", 32'(busy0), 32'h1);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("fe_dout0", 32'(dout0), 32'hC);
    checkOutput("fe_dv", 32'(dv0), 32'h1);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    checkOutput("fe_clr", 32'({fe0, fe1}), 32'h0);

    // Reset in the middle of a word.
    $display("[TB] mid-word reset");
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("mrst_cnt", 32'(cnt0), 32'h3);
    clr_n = 1'b0;
    #1;
    checkReset("mrst");
    @(posedge clk); #1;
    @(negedge clk);
    clr_n = 1'b1;
    applyStimulus(1'b1, 1'b0);
    checkOutput("mrst_ignored_busy", 32'(busy0), 32'h0);
    checkOutput("mrst_ignored_cnt", 32'(cnt0), 32'h0);
    sendWord(4'h6, 1'b1);
    checkOutput("mrst_dout0", 32'(dout0), 32'h6);
    checkOutput("mrst_dv", 32'(dv0), 32'h1);
    @(posedge clk); #1;

    // Back-to-back: last bit of the second word lands on the accept edge.
    $display("[TB] back-to-back");
    dout_ready = 1'b0;
    sendWord(4'h9, 1'b1);
    checkOutput("b2b_dv_w1", 32'(dv0), 32'h1);
    q0.push_back(4'h3);
    q1.push_back(rev4(4'h3));
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("b2b_dv_mid", 32'(dv0), 32'h1);
    dout_ready = 1'b1;
    applyStimulus(1'b0, 1'b0);
    checkOutput("b2b_dv_w2", 32'({dv0, dv1}), 32'h3);
    checkOutput("b2b_dout0", 32'(dout0), 32'h3);
    checkOutput("b2b_dout1", 32'(dout1), 32'hC);
    checkOutput("b2b_no_ovr", 32'({ov0, ov1}), 32'h0);
    @(posedge clk); #1;
    checkOutput("b2b_dv_end", 32'(dv0), 32'h0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("q0_empty", 32'(q0.size()), 32'h0);
    checkOutput("q1_empty", 32'(q1.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
